// File: rtl/cken_frac_gen.sv
// rtl/cken_frac_gen.sv - fractional clock-enable generator with per-channel phase accumulators and lock indication
//
// Each channel runs an ACC_W-bit phase accumulator.  On every cycle the channel's
// increment is added, and the carry out of the add becomes a single-cycle
// clock-enable pulse on the following cycle.  This gives an average pulse rate
// of inc / 2^ACC_W pulses per refclk cycle.  The phase register gives the
// accumulator start value, so several channels can be skewed against each other.
//
// Ports
//   refclk     : sole clock, all state updates on its rising edge
//   rst        : synchronous, active-high reset
//   cfg_valid  : configuration write request
//   cfg_ready  : high on every cycle after reset, so writes are never stalled
//   cfg_ch     : target channel of a write (out-of-range values are ignored)
//   cfg_inc    : per-cycle accumulator increment for the target channel
//   cfg_phase  : accumulator start value for the target channel
//   sync       : single-cycle pulse that reloads every accumulator from its phase
//   ch_enable  : per-channel run enable; a disabled channel freezes its accumulator
//   cken       : per-channel clock-enable pulses
//   locked     : configuration has been stable for LOCK_CYCLES cycles

module cken_frac_gen #(
    parameter int NUM_CH      = 4,
    parameter int ACC_W       = 32,
    parameter int LOCK_CYCLES = 1024,
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              refclk,
    input  logic              rst,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [ACC_W-1:0]  cfg_inc,
    input  logic [ACC_W-1:0]  cfg_phase,
    input  logic              sync,
    input  logic [NUM_CH-1:0] ch_enable,
    output logic [NUM_CH-1:0] cken,
    output logic              locked
);

    localparam int CNT_W = $clog2(LOCK_CYCLES + 1);

    typedef enum logic {
        SETTLE = 1'b0,
        LOCKED = 1'b1
    } lock_state_t;

    logic [ACC_W-1:0] inc_q   [NUM_CH];
    logic [ACC_W-1:0] phase_q [NUM_CH];
    logic [ACC_W-1:0] acc_q   [NUM_CH];
    logic [ACC_W:0]   sum     [NUM_CH];

    logic              accept;
    logic [NUM_CH-1:0] wr_sel;
    lock_state_t       state;
    logic [CNT_W-1:0]  cnt;

    assign accept = cfg_valid && cfg_ready;

    // One-hot channel select for an accepted write.  A cfg_ch value beyond the
    // last channel matches nothing, so the write only restarts the lock timer.
    always_comb begin
        wr_sel = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (accept && (cfg_ch == CH_W'(i))) begin
                wr_sel[i] = 1'b1;
            end
        end
    end

    // Extended-width add so the carry out is available as the pulse source.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            sum[i] = {1'b0, acc_q[i]} + {1'b0, inc_q[i]};
        end
    end

    always_ff @(posedge refclk) begin
        if (rst) begin
            cfg_ready <= 1'b0;
        end else begin
            cfg_ready <= 1'b1;
        end
    end

    // Channel datapath.  Priority: reset, direct write, sync reload, accumulate.
    // A write beats sync on its own channel so the fresh phase is what loads.
    // Any load suppresses the pulse for one cycle, so a realigned channel never
    // emits a stale carry from before the realignment.
    always_ff @(posedge refclk) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (rst) begin
                inc_q[i]   <= '0;
                phase_q[i] <= '0;
                acc_q[i]   <= '0;
                cken[i]    <= 1'b0;
            end else if (wr_sel[i]) begin
                inc_q[i]   <= cfg_inc;
                phase_q[i] <= cfg_phase;
                acc_q[i]   <= cfg_phase;
                cken[i]    <= 1'b0;
            end else if (sync) begin
                acc_q[i]   <= phase_q[i];
                cken[i]    <= 1'b0;
            end else if (ch_enable[i]) begin
                acc_q[i]   <= sum[i][ACC_W-1:0];
                cken[i]    <= sum[i][ACC_W];
            end else begin
                cken[i]    <= 1'b0;
            end
        end
    end

    // Lock tracker.  Any configuration change (write, including an out-of-range
    // one, or sync) restarts the settle count.  locked is registered alongside
    // the state so it follows the state with no extra cycle of delay.
    always_ff @(posedge refclk) begin
        if (rst) begin
            state  <= SETTLE;
            cnt    <= '0;
            locked <= 1'b0;
        end else if (accept || sync) begin
            state  <= SETTLE;
            cnt    <= '0;
            locked <= 1'b0;
        end else begin
            case (state)
                SETTLE: begin
                    if (cnt == CNT_W'(LOCK_CYCLES - 1)) begin
                        state  <= LOCKED;
                        locked <= 1'b1;
                    end else begin
                        cnt    <= cnt + 1'b1;
                        locked <= 1'b0;
                    end
                end
                LOCKED: begin
                    locked <= 1'b1;
                end
                default: begin
                    state  <= SETTLE;
                    cnt    <= '0;
                    locked <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cken_frac_gen.sv
// tb/tb_cken_frac_gen.sv - directed self-checking bench for cken_frac_gen

module tb_cken_frac_gen;

    localparam int NUM_CH      = 3;
    localparam int ACC_W       = 32;
    localparam int LOCK_CYCLES = 16;
    localparam int CH_W        = 2;

    logic              refclk = 1'b0;
    logic              rst;
    logic              cfg_valid;
    logic              cfg_ready;
    logic [CH_W-1:0]   cfg_ch;
    logic [ACC_W-1:0]  cfg_inc;
    logic [ACC_W-1:0]  cfg_phase;
    logic              sync;
    logic [NUM_CH-1:0] ch_enable;
    logic [NUM_CH-1:0] cken;
    logic              locked;

    int n_checks = 0;
    int n_err    = 0;

    always #5 refclk = ~refclk;

    cken_frac_gen #(
        .NUM_CH      (NUM_CH),
        .ACC_W       (ACC_W),
        .LOCK_CYCLES (LOCK_CYCLES)
    ) dut (
        .refclk    (refclk),
        .rst       (rst),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_inc   (cfg_inc),
        .cfg_phase (cfg_phase),
        .sync      (sync),
        .ch_enable (ch_enable),
        .cken      (cken),
        .locked    (locked)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one edge and settle away from it.
    task automatic tick();
        @(posedge refclk);
        #1;
    endtask

    task automatic write_cfg(input logic [CH_W-1:0] ch, input logic [ACC_W-1:0] inc,
                             input logic [ACC_W-1:0] ph);
        cfg_valid = 1'b1;
        cfg_ch    = ch;
        cfg_inc   = inc;
        cfg_phase = ph;
        tick();
        cfg_valid = 1'b0;
    endtask

    logic any_ck;
    int   n;

    initial begin
        // Reset with a write presented; it must be ignored.
        rst       = 1'b1;
        cfg_valid = 1'b1;
        cfg_ch    = 2'd0;
        cfg_inc   = 32'h8000_0000;
        cfg_phase = 32'h0000_0005;
        sync      = 1'b0;
        ch_enable = '0;
        repeat (3) tick();
        check("rst_cfg_ready", cfg_ready, 0);
        check("rst_locked", locked, 0);
        check("rst_cken", cken, 0);
        check("rst_write_ignored", dut.acc_q[0], 0);

        // Released with no configuration: lock after LOCK_CYCLES, no pulses.
        rst       = 1'b0;
        cfg_valid = 1'b0;
        ch_enable = 3'b111;
        any_ck    = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            tick();
            any_ck = any_ck | (|cken);
            if (k == 1)  check("ready_after_rst", cfg_ready, 1);
            if (k == 15) check("lock_rst_k15", locked, 0);
            if (k == 16) check("lock_rst_k16", locked, 1);
        end
        check("inc0_no_pulse", any_ck, 0);

        // ch0 half-rate: pulses after every 2nd add.
        write_cfg(2'd0, 32'h8000_0000, 32'h0);
        check("wr0_cken_zero", cken, 0);
        check("wr0_locked_drop", locked, 0);
        for (int k = 1; k <= 8; k++) begin
            tick();
            check($sformatf("ch0_half_k%0d", k), cken[0], (k % 2 == 0));
        end

        // ch1 quarter-rate with half-scale phase: first pulse after 2nd add.
        write_cfg(2'd1, 32'h4000_0000, 32'h8000_0000);
        for (int k = 1; k <= 10; k++) begin
            tick();
            check($sformatf("ch1_ph8_k%0d", k), cken[1], (k == 2 || k == 6 || k == 10));
        end

        // Same rate from phase 0: first pulse after 4th add; lock 16 later.
        write_cfg(2'd1, 32'h4000_0000, 32'h0);
        for (int k = 1; k <= 16; k++) begin
            tick();
            if (k <= 8) check($sformatf("ch1_ph0_k%0d", k), cken[1], (k % 4 == 0));
            if (k == 15) check("lock_w_k15", locked, 0);
            if (k == 16) check("lock_w_k16", locked, 1);
        end

        // Lock restart by a second write 10 cycles later (out-of-range channel).
        write_cfg(2'd1, 32'h0000_0001, 32'h1234_5678);
        check("wr1_locked_drop", locked, 0);
        for (int k = 1; k <= 9; k++) tick();
        write_cfg(2'd3, 32'hFFFF_FFFF, 32'hDEAD_0000);
        check("oor_ch1_untouched", dut.acc_q[1], 32'h1234_5682);
        check("oor_ch2_untouched", dut.acc_q[2], 0);
        check("oor_locked_low", locked, 0);
        for (int k = 1; k <= 16; k++) begin
            tick();
            if (k == 6)  check("lock_relock_k6", locked, 0);
            if (k == 15) check("lock_relock_k15", locked, 0);
            if (k == 16) check("lock_relock_k16", locked, 1);
        end

        // Sync together with a write to ch2; ch1 disabled but still reloads.
        ch_enable = 3'b101;
        sync      = 1'b1;
        write_cfg(2'd2, 32'h1000_0000, 32'h0000_1000);
        sync      = 1'b0;
        check("sync_acc2", dut.acc_q[2], 32'h0000_1000);
        check("sync_acc0", dut.acc_q[0], 0);
        check("sync_acc1_disabled", dut.acc_q[1], 32'h1234_5678);
        check("sync_cken", cken, 0);
        check("sync_locked", locked, 0);

        // ch0 gated off for 5 edges with its accumulator at half scale.
        for (int k = 1; k <= 11; k++) begin
            if (k == 4) ch_enable = 3'b100;
            if (k == 9) ch_enable = 3'b101;
            tick();
            check($sformatf("gate_k%0d", k), cken[0], (k == 2 || k == 9 || k == 11));
            if (k == 8) check("gate_acc_frozen", dut.acc_q[0], 32'h8000_0000);
        end

        // Reach lock, then reset while running.
        n = 0;
        while (!locked && n < 40) begin
            tick();
            n++;
        end
        check("pre_rst_locked", locked, 1);
        ch_enable = 3'b111;
        rst       = 1'b1;
        tick();
        check("midrst_cken", cken, 0);
        check("midrst_locked", locked, 0);
        check("midrst_ready", cfg_ready, 0);
        rst    = 1'b0;
        any_ck = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            any_ck = any_ck | (|cken);
        end
        check("post_rst_no_pulse", any_ck, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/cken_frac_gen.md
CKEN_FRAC_GEN -- requirements
Module: cken_frac_gen

Interface
REQ-001 Parameter NUM_CH, default 4: number of independent clock-enable channels, range 1..16.
REQ-002 Parameter ACC_W, default 32: phase-accumulator width in bits, range 8..48.
REQ-003 Parameter LOCK_CYCLES, default 1024: settle time in refclk cycles before locked asserts, range 2..65535.
REQ-004 refclk  in  1  sole clock; all logic on its rising edge.
REQ-005 rst  in  1  reset, synchronous and active-high.
REQ-006 cfg_valid  in  1  configuration write request.
REQ-007 cfg_ready  out  1  block can accept a configuration write.
REQ-008 cfg_ch  in  max(1,clog2(NUM_CH))  target channel of the write.
REQ-009 cfg_inc  in  ACC_W  per-cycle accumulator increment (f_out/f_refclk * 2^ACC_W).
REQ-010 cfg_phase  in  ACC_W  accumulator start value (phase offset).
REQ-011 sync  in  1  single-cycle pulse: realign all channels to their stored phase.
REQ-012 ch_enable  in  NUM_CH  per-channel run enable.
REQ-013 cken  out  NUM_CH  per-channel single-cycle clock-enable pulses.
REQ-014 locked  out  1  configuration stable for LOCK_CYCLES cycles.

Function
REQ-015 Per-channel registers: inc[i], phase[i], acc[i], all ACC_W bits.
REQ-016 A write is accepted on an edge where cfg_valid=1 and cfg_ready=1; on that edge inc[cfg_ch]<=cfg_inc, phase[cfg_ch]<=cfg_phase, acc[cfg_ch]<=cfg_phase.
REQ-017 cfg_ch >= NUM_CH: write accepted, no channel register altered, lock FSM still restarts settle.
REQ-018 cfg_ready is 0 during reset and 1 on every cycle thereafter; writes are never back-pressured.
REQ-019 On every edge without a load (no write to i, no sync) and with ch_enable[i]=1: {carry,acc[i]} <= acc[i] + inc[i], sum taken mod 2^ACC_W, carry is bit ACC_W.
REQ-020 cken[i] is registered: it equals the carry produced on the previous edge; latency from the carrying add to cken high is one cycle.
REQ-021 ch_enable[i]=0: acc[i] holds and cken[i] is 0 on the following cycle; on re-enable, accumulation resumes from the held value.
REQ-022 inc[i]=0: cken[i] never asserts.
REQ-023 Any edge that loads acc[i] (write or sync) drives cken[i] to 0 for the following cycle.
REQ-024 sync=1: acc[i]<=phase[i] for every channel, including disabled ones.
REQ-025 sync and an accepted write on the same edge: the written channel loads cfg_phase; all other channels load their stored phase.
REQ-026 Lock FSM states: SETTLE, LOCKED. Counter width is clog2(LOCK_CYCLES+1).
REQ-027 SETTLE: counter increments each cycle; when counter = LOCK_CYCLES-1, next state LOCKED.
REQ-028 An accepted write or sync, in either state, sets next state SETTLE with counter 0; this takes precedence over the REQ-027 transition.
REQ-029 locked = registered (state==LOCKED); it deasserts the cycle after a write or sync edge.
REQ-030 ch_enable has no effect on the lock FSM.

Reset
REQ-031 While rst=1 at an edge: all inc, phase and acc registers are 0, cken=0, locked=0, cfg_ready=0, state SETTLE, counter 0.
REQ-032 Reset asserted mid-operation discards all configuration and pending pulses on that edge; writes presented during reset are ignored.
REQ-033 After rst deasserts with no writes or sync, locked asserts LOCK_CYCLES cycles later and cken stays 0.

Verification
REQ-034 ACC_W=32, write ch0 inc=0x8000_0000 phase=0 on edge E0, ch_enable=1 -> cken[0] low after E1, high after E2, then alternates with period 2.
REQ-035 Write ch1 inc=0x4000_0000 phase=0x8000_0000 -> first cken[1] after the 2nd add, then every 4 cycles; the same inc with phase 0 -> first pulse after the 4th add.
REQ-036 LOCK_CYCLES=16, write at cycle 0 -> locked rises 16 cycles later; a second write at cycle 10 -> locked low until 16 cycles after the second write.
REQ-037 Simultaneous sync and write to ch2 with phase=0x1000 -> acc[2]=0x1000, other channels equal their stored phases, cken all 0 next cycle, locked drops.
REQ-038 ch_enable[0] low for 5 cycles mid-stream -> no pulses during that window, acc[0] frozen, pulse spacing resumes unchanged afterwards.
REQ-039 rst pulsed while channels run and locked=1 -> next cycle cken=0, locked=0, cfg_ready=0; no pulses until reconfigured.
